bank_queue_ctrl: RTL and testbench
==================================

BANK_QUEUE_CTRL -- requirements
Module: bank_queue_ctrl

Interface
REQ-001 SHALL have parameter MAX_PEOPLE, default 7, meaning the queue capacity; legal range 1..10.
REQ-002 SHALL have parameter DEB_CYCLES, default 4, meaning the debounce stability window in clocks; legal range 2..255; used only with SENSOR_DEBOUNCE_EN.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning the asynchronous active-high reset.
REQ-005 SHALL have port front_sensor, input, 1 bit, meaning the asynchronous entry photocell; high while a customer is passing.
REQ-006 SHALL have port back_sensor, input, 1 bit, meaning the asynchronous exit photocell; high while a customer is passing.
REQ-007 SHALL have port tcount, input, 2 bits, meaning the number of active tellers (0..3); quasi-static.
REQ-008 SHALL have port pcount, output, 4 bits, meaning the registered people-in-queue count, driving the display block.
REQ-009 SHALL have port wtime, output, 5 bits, meaning the registered estimated wait in minutes, driving the display block.
REQ-010 SHALL have port full, output, 1 bit, meaning pcount == MAX_PEOPLE; registered.
REQ-011 SHALL have port empty, output, 1 bit, meaning pcount == 0; registered.
REQ-012 SHALL have port reject, output, 1 bit, meaning a one-cycle pulse when an entry event is dropped because the queue is full.

Function
REQ-013 SHALL pass each sensor through a 2-flop synchronizer, then a rising-edge detector; one rising edge SHALL be one event, and a held-high sensor SHALL give no further events.
REQ-014 SHALL, without debounce, update pcount on the 3rd rising clk edge at which the sensor is sampled high (fixed latency 3).
REQ-015 SHALL apply the count update rules: entry only -> pcount+1; exit only -> pcount-1; entry and exit in the same cycle -> pcount unchanged, even when full or empty.
REQ-016 SHALL, on entry only while full, leave pcount unchanged and assert reject for exactly one cycle.
REQ-017 SHALL, on exit only while empty, leave pcount unchanged with no flag.
REQ-018 SHALL compute wtime from pcount one cycle after each pcount change (latency 1).
REQ-019 SHALL compute wtime as: t = (tcount==0) ? 1 : tcount; wtime = (pcount==0) ? 0 : floor(3*(pcount+t-1)/t); result ≤ 30, fits 5 bits.
REQ-020 SHALL update wtime within 1 cycle when tcount changes, with no pcount change.
REQ-021 SHALL update full and empty in the same cycle as pcount.
REQ-022 SHALL implement each sensor path as an FSM with states IDLE -> HIGH on synchronized 1, HIGH -> IDLE on synchronized 0; the event fires on the IDLE->HIGH transition only.

Reset
REQ-023 SHALL, with rst asserted, asynchronously force pcount=0, wtime=0, full=0, empty=1, reject=0, synchronizers=0, FSMs=IDLE, and debounce counters=0.
REQ-024 SHALL, when rst is asserted mid-event, discard the event; a sensor still high at rst release SHALL count as a new event after the normal latency.

Configuration
REQ-025 SHALL, with SENSOR_DEBOUNCE_EN defined, require the synchronized sensor to be stable at its new level for DEB_CYCLES consecutive clocks before an FSM transition; glitches shorter than this SHALL be ignored; entry latency becomes 2+DEB_CYCLES+1.
REQ-026 SHALL, with SENSOR_DEBOUNCE_EN undefined, use no debounce counters and keep latency 3 per REQ-014.

Structure
REQ-027 SHALL place in package bank_pkg: MIN_PER_CUSTOMER=3, PCOUNT_W=4, WTIME_W=5, TCOUNT_W=2, and the sensor FSM state enum.
REQ-028 SHALL have one sub-module, bank_sensor_edge (synchronizer, optional debounce, FSM, 1-cycle event pulse), instantiated for the front sensor and for the back sensor.
REQ-029 SHALL implement the wtime division as a small case over (pcount, t) or constant-divisor logic; no generic divider.

Verification
REQ-030 SHALL check: reset, then 3 front pulses, each 5 cycles high, with tcount=1 -> pcount=3, wtime=9, empty=0.
REQ-031 SHALL check: pcount=5, then tcount switches 1->2 -> wtime goes 15->9 one cycle later; tcount=0 -> wtime=15.
REQ-032 SHALL check: fill to 7 (MAX_PEOPLE=7), then 1 more front pulse -> pcount stays 7, full=1, one reject pulse.
REQ-033 SHALL check: front and back edges synchronized in the same cycle at pcount=0 and at pcount=7 -> pcount unchanged, no reject.
REQ-034 SHALL check: back pulse at pcount=0 -> pcount=0, empty=1; and rst asserted for 1 cycle mid-count -> all outputs at reset values immediately, without waiting for clk.
REQ-035 SHALL check, with SENSOR_DEBOUNCE_EN and DEB_CYCLES=4: a 2-cycle front glitch -> no count; a 10-cycle pulse -> pcount+1 exactly 7 edges after the rise.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared widths, constants, sensor FSM state type and the wait-time helper for the bank
// queue controller.
package bank_pkg;

   localparam int unsigned MIN_PER_CUSTOMER = 3;
   localparam int unsigned PCOUNT_W         = 4;
   localparam int unsigned WTIME_W          = 5;
   localparam int unsigned TCOUNT_W         = 2;

   typedef enum logic {
      SensIdle,
      SensHigh
   } sens_state_e;

   // Divisor is always a constant 1, 2 or 3, so each branch becomes small fixed logic.
   // Zero tellers behaves like one teller.
   function automatic logic [WTIME_W-1:0] calc_wtime(logic [PCOUNT_W-1:0] p,
                                                     logic [TCOUNT_W-1:0] tc);
      logic [7:0] n;
      logic [7:0] q;
      n = 8'(p);
      case (tc)
         2'd0, 2'd1: q = 8'(MIN_PER_CUSTOMER) * n;
         2'd2:       q = (8'(MIN_PER_CUSTOMER) * (n + 8'd1)) / 8'd2;
         default:    q = (8'(MIN_PER_CUSTOMER) * (n + 8'd2)) / 8'd3;
      endcase
      if (p == '0) q = '0;
      return q[WTIME_W-1:0];
   endfunction

endpackage

// File: rtl/bank_sensor_edge.sv
// Photocell front end: 2-flop synchronizer, optional debounce (SENSOR_DEBOUNCE_EN) and an
// IDLE/HIGH FSM that emits a one-cycle event on each accepted rising edge.
module bank_sensor_edge
   import bank_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sensor,
   output logic evt
);

   if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_deb
      $error("DEB_CYCLES out of range 2..255");
   end

   logic [1:0]  sync;
   logic        s;
   sens_state_e state;

   assign s = sync[1];

`ifdef SENSOR_DEBOUNCE_EN
   logic [7:0] deb_cnt;
   logic       lvl;
   logic       settled;

   assign lvl     = (state == SensHigh);
   assign settled = (deb_cnt == 8'(DEB_CYCLES));

   // The counter tracks how long the synchronized level has differed from the FSM level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync    <= '0;
         state   <= SensIdle;
         deb_cnt <= '0;
      end else begin
         sync <= {sync[0], sensor};
         if (s != lvl) begin
            if (settled) begin
               state   <= s ? SensHigh : SensIdle;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 8'd1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   assign evt = (state == SensIdle) && s && settled;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         state <= SensIdle;
      end else begin
         sync  <= {sync[0], sensor};
         state <= s ? SensHigh : SensIdle;
      end
   end

   // Decoded from the registered state so the count lands on the edge of the transition.
   assign evt = (state == SensIdle) && s;
`endif

endmodule

// File: rtl/bank_queue_ctrl.sv
// Bank queue people counter with wait-time estimate; sensor debounce is enabled by defining
// SENSOR_DEBOUNCE_EN.
module bank_queue_ctrl
   import bank_pkg::*;
#(
   parameter int unsigned MAX_PEOPLE = 7,
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                front_sensor,
   input  logic                back_sensor,
   input  logic [TCOUNT_W-1:0] tcount,
   output logic [PCOUNT_W-1:0] pcount,
   output logic [WTIME_W-1:0]  wtime,
   output logic                full,
   output logic                empty,
   output logic                reject
);

   if (MAX_PEOPLE < 1 || MAX_PEOPLE > 10) begin : g_bad_max
      $error("MAX_PEOPLE out of range 1..10");
   end

   localparam logic [PCOUNT_W-1:0] MaxCnt = PCOUNT_W'(MAX_PEOPLE);

   logic                entry_evt;
   logic                exit_evt;
   logic [PCOUNT_W-1:0] pcount_d;
   logic                reject_d;

   bank_sensor_edge #(.DEB_CYCLES(DEB_CYCLES)) u_front (
      .clk    (clk),
      .rst    (rst),
      .sensor (front_sensor),
      .evt    (entry_evt)
   );

   bank_sensor_edge #(.DEB_CYCLES(DEB_CYCLES)) u_back (
      .clk    (clk),
      .rst    (rst),
      .sensor (back_sensor),
      .evt    (exit_evt)
   );

   // Simultaneous entry and exit cancel regardless of full/empty.
   always_comb begin
      pcount_d = pcount;
      reject_d = 1'b0;
      if (entry_evt && !exit_evt) begin
         if (full) reject_d = 1'b1;
         else      pcount_d = pcount + 4'd1;
      end else if (exit_evt && !entry_evt) begin
         if (!empty) pcount_d = pcount - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcount <= '0;
         wtime  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         reject <= 1'b0;
      end else begin
         pcount <= pcount_d;
         full   <= (pcount_d == MaxCnt);
         empty  <= (pcount_d == '0);
         reject <= reject_d;
         wtime  <= calc_wtime(pcount, tcount);
      end
   end

endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Directed self-checking bench for bank_queue_ctrl; covers the debounce window too when
// SENSOR_DEBOUNCE_EN is defined.
module tb_bank_queue_ctrl;

   localparam int unsigned MAXP = 7;
   localparam int unsigned DEB  = 4;
`ifdef SENSOR_DEBOUNCE_EN
   localparam int LAT = 2 + DEB + 1;
   localparam int HI  = 10;
`else
   localparam int LAT = 3;
   localparam int HI  = 5;
`endif
   localparam int GAP = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       front = 1'b0;
   logic       back = 1'b0;
   logic [1:0] tcount = 2'd1;
   logic [3:0] pcount;
   logic [4:0] wtime;
   logic       full;
   logic       empty;
   logic       reject;

   int n_checks = 0;
   int n_fail = 0;
   int rej_seen = 0;
   int r0;

   always #5 clk = ~clk;

   bank_queue_ctrl #(.MAX_PEOPLE(MAXP), .DEB_CYCLES(DEB)) dut (
      .clk          (clk),
      .rst          (rst),
      .front_sensor (front),
      .back_sensor  (back),
      .tcount       (tcount),
      .pcount       (pcount),
      .wtime        (wtime),
      .full         (full),
      .empty        (empty),
      .reject       (reject)
   );

   always @(negedge clk) if (reject === 1'b1) rej_seen <= rej_seen + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse(input logic f, input logic b, input int hi);
      front = f;
      back  = b;
      repeat (hi) @(negedge clk);
      front = 1'b0;
      back  = 1'b0;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_pcount"}, 32'(pcount), 0);
      check_eq({tag, "_wtime"},  32'(wtime),  0);
      check_eq({tag, "_full"},   32'(full),   0);
      check_eq({tag, "_empty"},  32'(empty),  1);
      check_eq({tag, "_reject"}, 32'(reject), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      rst = 1'b0;
      @(negedge clk);

      // First entry: latency and wtime lag
      front = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      check_eq("lat_before", 32'(pcount), 0);
      @(negedge clk);
      check_eq("lat_at", 32'(pcount), 1);
      check_eq("empty_same_cycle", 32'(empty), 0);
      check_eq("wtime_lag", 32'(wtime), 0);
      @(negedge clk);
      check_eq("wtime_after", 32'(wtime), 3);
      repeat (HI - LAT - 1) @(negedge clk);
      front = 1'b0;
      repeat (GAP) @(negedge clk);
      check_eq("held_one_event", 32'(pcount), 1);

      repeat (2) pulse(1'b1, 1'b0, HI);
      check_eq("p3_pcount", 32'(pcount), 3);
      check_eq("p3_wtime", 32'(wtime), 9);
      check_eq("p3_empty", 32'(empty), 0);
      check_eq("p3_full", 32'(full), 0);

      repeat (2) pulse(1'b1, 1'b0, HI);
      check_eq("p5_pcount", 32'(pcount), 5);
      check_eq("p5_t1_wtime", 32'(wtime), 15);
      tcount = 2'd2;
      check_eq("t2_hold", 32'(wtime), 15);
      @(negedge clk);
      check_eq("t2_wtime", 32'(wtime), 9);
      tcount = 2'd0;
      @(negedge clk);
      check_eq("t0_wtime", 32'(wtime), 15);
      tcount = 2'd3;
      @(negedge clk);
      check_eq("t3_wtime", 32'(wtime), 7);
      tcount = 2'd1;
      @(negedge clk);

      repeat (2) pulse(1'b1, 1'b0, HI);
      check_eq("fill_pcount", 32'(pcount), 7);
      check_eq("fill_full", 32'(full), 1);
      check_eq("fill_wtime", 32'(wtime), 21);
      check_eq("fill_no_reject", 32'(rej_seen), 0);

      r0 = rej_seen;
      pulse(1'b1, 1'b0, HI);
      check_eq("over_pcount", 32'(pcount), 7);
      check_eq("over_full", 32'(full), 1);
      check_eq("over_reject_cnt", 32'(rej_seen - r0), 1);

      r0 = rej_seen;
      pulse(1'b1, 1'b1, HI);
      check_eq("both_full_pcount", 32'(pcount), 7);
      check_eq("both_full_reject", 32'(rej_seen - r0), 0);

      pulse(1'b0, 1'b1, HI);
      check_eq("exit_full_clr", 32'(full), 0);
      repeat (6) pulse(1'b0, 1'b1, HI);
      check_eq("drain_pcount", 32'(pcount), 0);
      check_eq("drain_empty", 32'(empty), 1);
      check_eq("drain_wtime", 32'(wtime), 0);

      r0 = rej_seen;
      pulse(1'b1, 1'b1, HI);
      check_eq("both_empty_pcount", 32'(pcount), 0);
      check_eq("both_empty_reject", 32'(rej_seen - r0), 0);

      pulse(1'b0, 1'b1, HI);
      check_eq("exit_empty_pcount", 32'(pcount), 0);
      check_eq("exit_empty_empty", 32'(empty), 1);

      repeat (2) pulse(1'b1, 1'b0, HI);
      check_eq("pre_rst_pcount", 32'(pcount), 2);
      check_eq("pre_rst_wtime", 32'(wtime), 6);

      // Asynchronous reset mid-event; sensor stays high across release
      front = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals("async_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      check_eq("post_rst_before", 32'(pcount), 0);
      @(negedge clk);
      check_eq("post_rst_event", 32'(pcount), 1);
      front = 1'b0;
      repeat (GAP) @(negedge clk);

`ifdef SENSOR_DEBOUNCE_EN
      pulse(1'b1, 1'b0, 2);
      check_eq("glitch_ignored", 32'(pcount), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
